// File: rtl/board_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : board_io_pkg
//  Purpose  : Shared constants for the board I/O responder: register indices,
//             responder FSM states and the seven-segment glyph table.
//  Revision : 1.0 - initial release
// ============================================================================
package board_io_pkg;

    // Word register indices on the request bus
    localparam logic [3:0] IDX_LEDR      = 4'd0;
    localparam logic [3:0] IDX_LEDG      = 4'd1;
    localparam logic [3:0] IDX_HEXVAL    = 4'd2;
    localparam logic [3:0] IDX_SW        = 4'd3;
    localparam logic [3:0] IDX_KEY_LEVEL = 4'd4;
    localparam logic [3:0] IDX_KEY_EVENT = 4'd5;

    // Responder FSM: one request in flight at a time
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
    // Letters b and d are lowercase so they are not confused with 8 and 0.
    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_io_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : board_io_responder_if
//  Purpose  : Request/response bus between an initiator and the board I/O
//             responder. A request is taken when req_valid && req_ready; the
//             response is taken when resp_valid && resp_ready.
//  Revision : 1.0 - initial release
// ============================================================================
interface board_io_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : input_debounce
//  Purpose  : Per-bit two-flop synchronizer followed by a counter debouncer.
//             A bit's stable value only changes after the synchronized input
//             has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
//             stable_next_o exposes the value the stable flop takes on the
//             next edge so the parent can act on a change in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module input_debounce #(
    parameter int               WIDTH           = 1,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] async_i,
    output logic      [WIDTH-1:0] stable_o,
    output logic      [WIDTH-1:0] stable_next_o
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1
    localparam int             CW        = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Two-stage synchronizer; resets to the idle level so no false edge appears
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          stable_q;
        logic          stable_d;

        // Count consecutive disagreeing cycles; accept on the last one
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (sync2_q[i] != stable_q) begin
                if (cnt_q == C_CNT_MAX) begin
                    stable_d = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        // Debounce state registers
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q    <= '0;
                stable_q <= RESET_VALUE[i];
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign stable_o[i]      = stable_q;
        assign stable_next_o[i] = stable_d;
    end

endmodule
`default_nettype wire

// File: rtl/board_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : board_io_responder
//  Purpose  : Bus-mapped register block for the board LEDs, seven-segment
//             displays, slide switches and pushbuttons. One transaction is
//             in flight at a time: accept in IDLE, answer from RESP.
//  Revision : 1.0 - initial release
// ============================================================================
module board_io_responder
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic            CLOCK_50,
    input  wire logic            RESET,
    board_io_responder_if.slave  bus,
    input  wire logic [9:0]      SW,
    input  wire logic [3:0]      KEY,
    output logic      [7:0]      LEDR,
    output logic      [7:0]      LEDG,
    output logic      [6:0]      HEX0,
    output logic      [6:0]      HEX1,
    output logic      [6:0]      HEX2,
    output logic      [6:0]      HEX3
);

    state_e      state_q, state_d;
    logic [7:0]  ledr_q, ledr_d;
    logic [7:0]  ledg_q, ledg_d;
    logic [15:0] hexval_q, hexval_d;
    logic [3:0]  key_event_q, key_event_d;
    logic [31:0] rdata_q, rdata_d;

    logic [9:0]  w_sw_stable;
    logic [9:0]  w_sw_stable_next;
    logic [3:0]  w_key_stable;
    logic [3:0]  w_key_stable_next;
    logic [3:0]  w_key_level;
    logic [3:0]  w_key_rise;
    logic [3:0]  w_event_clr;
    logic [31:0] w_read_data;
    logic        w_unused_bits;

    input_debounce #(
        .WIDTH           (10),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (10'h000)
    ) u_sw_debounce (
        .clk           (CLOCK_50),
        .rst           (RESET),
        .async_i       (SW),
        .stable_o      (w_sw_stable),
        .stable_next_o (w_sw_stable_next)
    );

    // Buttons idle high, so the debounced state starts as "not pressed"
    input_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (4'b1111)
    ) u_key_debounce (
        .clk           (CLOCK_50),
        .rst           (RESET),
        .async_i       (KEY),
        .stable_o      (w_key_stable),
        .stable_next_o (w_key_stable_next)
    );

    assign w_key_level = ~w_key_stable;
    // A press is registered on the same edge that the level flop goes high
    assign w_key_rise  = ~w_key_stable_next & w_key_stable;

    // Read mux over current register values (pre-update)
    always_comb begin
        w_read_data = '0;
        case (bus.req_addr)
            IDX_LEDR:      w_read_data = {24'b0, ledr_q};
            IDX_LEDG:      w_read_data = {24'b0, ledg_q};
            IDX_HEXVAL:    w_read_data = {16'b0, hexval_q};
            IDX_SW:        w_read_data = {22'b0, w_sw_stable};
            IDX_KEY_LEVEL: w_read_data = {28'b0, w_key_level};
            IDX_KEY_EVENT: w_read_data = {28'b0, key_event_q};
            default:       w_read_data = '0;
        endcase
    end

    // Next-state: FSM, register writes, response data and event bookkeeping
    always_comb begin
        state_d     = state_q;
        ledr_d      = ledr_q;
        ledg_d      = ledg_q;
        hexval_d    = hexval_q;
        rdata_d     = rdata_q;
        w_event_clr = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_RESP;
                    rdata_d = bus.req_we ? 32'h0 : w_read_data;
                    if (bus.req_we) begin
                        case (bus.req_addr)
                            IDX_LEDR:      ledr_d      = bus.req_wdata[7:0];
                            IDX_LEDG:      ledg_d      = bus.req_wdata[7:0];
                            IDX_HEXVAL:    hexval_d    = bus.req_wdata[15:0];
                            IDX_KEY_EVENT: w_event_clr = bus.req_wdata[3:0];
                            default:       ;
                        endcase
                    end
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // New presses take priority over a coincident clear
        key_event_d = (key_event_q & ~w_event_clr) | w_key_rise;
    end

    // State registers
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            ledr_q      <= '0;
            ledg_q      <= '0;
            hexval_q    <= '0;
            key_event_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ledr_q      <= ledr_d;
            ledg_q      <= ledg_d;
            hexval_q    <= hexval_d;
            key_event_q <= key_event_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;

    assign LEDR = ledr_q;
    assign LEDG = ledg_q;
    assign HEX0 = seg_decode(hexval_q[3:0]);
    assign HEX1 = seg_decode(hexval_q[7:4]);
    assign HEX2 = seg_decode(hexval_q[11:8]);
    assign HEX3 = seg_decode(hexval_q[15:12]);

    // Upper write-data bits and the look-ahead switch value have no consumer
    assign w_unused_bits = &{1'b0, bus.req_wdata[31:16], w_sw_stable_next};

endmodule
`default_nettype wire

// File: tb/tb_board_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_io_responder
//  Purpose  : Self-checking bench for board_io_responder with a short
//             debounce window; directed scenarios plus randomized register
//             traffic checked against a register-map model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_board_io_responder;

    localparam int DC     = 4;
    // Input must cross two synchronizer flops, then persist DC cycles
    localparam int SETTLE = DC + 2 + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic [7:0]  ledr, ledg;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int checks = 0;
    int errors = 0;

    // Architectural model of the register map
    logic [7:0]  m_ledr, m_ledg;
    logic [15:0] m_hex;
    logic [3:0]  m_kev;
    logic [9:0]  m_sw;
    logic [3:0]  m_klev;

    board_io_responder_if bus ();

    board_io_responder #(
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus),
        .SW       (sw),
        .KEY      (key),
        .LEDR     (ledr),
        .LEDG     (ledg),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:    return {24'b0, m_ledr};
            4'd1:    return {24'b0, m_ledg};
            4'd2:    return {16'b0, m_hex};
            4'd3:    return {22'b0, m_sw};
            4'd4:    return {28'b0, m_klev};
            4'd5:    return {28'b0, m_kev};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("LEDR", 32'(ledr), 32'(m_ledr));
        chk("LEDG", 32'(ledg), 32'(m_ledg));
        chk("HEX0", 32'(hex0), 32'(seg(m_hex[3:0])));
        chk("HEX1", 32'(hex1), 32'(seg(m_hex[7:4])));
        chk("HEX2", 32'(hex2), 32'(seg(m_hex[11:8])));
        chk("HEX3", 32'(hex3), 32'(seg(m_hex[15:12])));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus transaction; entered and left 1 time unit after a rising edge
    task automatic txn(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                       input int hold, output logic [31:0] rd);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        chk("resp_valid_idle", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wdata = $urandom;
        chk("resp_valid_rise", 32'(bus.resp_valid), 32'd1);
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        rd = bus.resp_rdata;
        for (int i = 0; i < hold; i++) begin
            cycles(1);
            chk("resp_valid_hold", 32'(bus.resp_valid), 32'd1);
            chk("resp_rdata_hold", bus.resp_rdata, rd);
            chk("req_ready_hold", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
    endtask

    // Transaction checked against the model, which is then updated
    task automatic do_op(input string tag, input logic we, input logic [3:0] addr,
                         input logic [31:0] wd, input int hold);
        logic [31:0] exp, rd;
        exp = we ? 32'h0 : model_read(addr);
        txn(we, addr, wd, hold, rd);
        chk(tag, rd, exp);
        if (we) begin
            case (addr)
                4'd0:    m_ledr = wd[7:0];
                4'd1:    m_ledg = wd[7:0];
                4'd2:    m_hex  = wd[15:0];
                4'd5:    m_kev  = m_kev & ~wd[3:0];
                default: ;
            endcase
        end
        chk_outputs();
    endtask

    initial begin
        logic [9:0] old_sw;
        logic [3:0] a;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 4'd0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        sw  = 10'h000;
        key = 4'hF;
        rst = 1'b1;
        m_ledr = 8'h0; m_ledg = 8'h0; m_hex = 16'h0; m_kev = 4'h0;
        m_sw = 10'h0; m_klev = 4'h0;
        cycles(3);
        rst = 1'b0;

        // Reset state
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk_outputs();
        chk("rst_hex0_glyph", 32'(hex0), 32'h40);
        do_op("rst_read_sw", 1'b0, 4'd3, 32'h0, 0);
        do_op("rst_read_keylvl", 1'b0, 4'd4, 32'h0, 0);
        do_op("rst_read_kev", 1'b0, 4'd5, 32'h0, 0);

        // LEDR write/read-back
        do_op("wr_ledr", 1'b1, 4'd0, 32'h0000_00A5, 0);
        do_op("rd_ledr", 1'b0, 4'd0, 32'h0, 0);
        chk("ledr_a5", 32'(ledr), 32'hA5);

        // Hex display glyphs
        do_op("wr_hex", 1'b1, 4'd2, 32'hFFFF_12EF, 0);
        chk("hex3_1", 32'(hex3), 32'b1111001);
        chk("hex2_2", 32'(hex2), 32'b0100100);
        chk("hex1_E", 32'(hex1), 32'b0000110);
        chk("hex0_F", 32'(hex0), 32'b0001110);
        do_op("rd_hex", 1'b0, 4'd2, 32'h0, 0);

        // Read-only and unmapped indices ignore writes but still respond
        do_op("wr_sw_ro", 1'b1, 4'd3, 32'hFFFF_FFFF, 0);
        do_op("wr_unmapped", 1'b1, 4'd9, 32'hFFFF_FFFF, 1);
        do_op("rd_unmapped", 1'b0, 4'd9, 32'h0, 0);

        // Switch glitch shorter than the window is ignored
        sw = 10'h3FF;
        cycles(3);
        sw = 10'h000;
        cycles(SETTLE);
        do_op("sw_glitch", 1'b0, 4'd3, 32'h0, 0);
        sw = 10'h3FF;
        cycles(10);
        m_sw = 10'h3FF;
        do_op("sw_held", 1'b0, 4'd3, 32'h0, 0);

        // Key press sets the sticky event; level follows the held button
        key = 4'b1101;
        cycles(SETTLE);
        m_klev = 4'b0010;
        m_kev  = m_kev | 4'b0010;
        do_op("key_level_held", 1'b0, 4'd4, 32'h0, 0);
        key = 4'hF;
        cycles(SETTLE);
        m_klev = 4'b0000;
        do_op("key_level_rel", 1'b0, 4'd4, 32'h0, 0);
        do_op("kev_read1", 1'b0, 4'd5, 32'h0, 0);
        do_op("kev_read_keeps", 1'b0, 4'd5, 32'h0, 0);
        do_op("kev_clr1", 1'b1, 4'd5, 32'h2, 0);

        key = 4'b1011;
        cycles(10);
        key = 4'hF;
        cycles(SETTLE);
        m_kev = m_kev | 4'b0100;
        do_op("kev_key2", 1'b0, 4'd5, 32'h0, 0);
        do_op("kev_clr2", 1'b1, 4'd5, 32'h4, 0);
        do_op("kev_cleared", 1'b0, 4'd5, 32'h0, 0);

        // Press lands DC+2 edges after the input changes; clear on that edge
        key = 4'b1011;
        cycles(DC + 1);
        do_op("kev_coincide_wr", 1'b1, 4'd5, 32'h4, 0);
        m_kev = m_kev | 4'b0100;
        cycles(SETTLE);
        key = 4'hF;
        cycles(SETTLE);
        do_op("kev_set_wins", 1'b0, 4'd5, 32'h0, 0);
        do_op("kev_clr3", 1'b1, 4'd5, 32'h4, 0);

        // Clear one edge after the press: the clear takes effect
        key = 4'b1011;
        cycles(DC + 2);
        m_kev = m_kev | 4'b0100;
        do_op("kev_late_clr_wr", 1'b1, 4'd5, 32'h4, 0);
        key = 4'hF;
        cycles(SETTLE);
        do_op("kev_late_clr", 1'b0, 4'd5, 32'h0, 0);

        // Response held across a stalled initiator
        do_op("stall_read", 1'b0, 4'd0, 32'h0, 5);

        // Randomized traffic with occasional switch changes and glitches
        for (int n = 0; n < 40; n++) begin
            if (n % 10 == 0) begin
                sw = 10'($urandom);
                cycles(SETTLE);
                m_sw = sw;
                old_sw = sw;
                sw = 10'($urandom);
                cycles($urandom_range(1, DC - 1));
                sw = old_sw;
                cycles(SETTLE);
            end
            a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15))
                                            : 4'($urandom_range(0, 5));
            do_op("rand_op", 1'($urandom_range(0, 1)), a, $urandom,
                  int'($urandom_range(0, 3)));
        end

        // Reset while a response is pending drops it
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd0;
        bus.req_wdata = 32'h5A;
        cycles(1);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        chk("pre_rst_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("pre_rst_ledr", 32'(ledr), 32'h5A);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        m_ledr = 8'h0; m_ledg = 8'h0; m_hex = 16'h0; m_kev = 4'h0; m_klev = 4'h0;
        chk("rst_resp_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk_outputs();
        cycles(SETTLE);
        m_sw = sw;
        do_op("post_rst_sw", 1'b0, 4'd3, 32'h0, 0);
        do_op("post_rst_kev", 1'b0, 4'd5, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_io_responder.md
BOARD_IO_RESPONDER -- requirements
Module: board_io_responder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required before an input change is accepted (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 CLOCK_50  in  1  sole clock; every flop is clocked on its rising edge.
REQ-003 RESET  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  bus request present.
REQ-005 req_ready  out  1  request accepted this cycle when req_valid is also high.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  4  word register index.
REQ-008 req_wdata  in  32  write data.
REQ-009 resp_valid  out  1  response present.
REQ-010 resp_ready  in  1  initiator takes the response.
REQ-011 resp_rdata  out  32  read data; 0 for writes.
REQ-012 SW  in  10  board slide switches, asynchronous.
REQ-013 KEY  in  4  board pushbuttons, active-low, asynchronous.
REQ-014 LEDR  out  8  red LEDs.
REQ-015 LEDG  out  8  green LEDs.
REQ-016 HEX0, HEX1, HEX2, HEX3  out  7 each  seven-segment digits, active-low; bit 0 = segment a ... bit 6 = segment g.

Function
REQ-017 Register map (index: contents): 0 LEDR[7:0] RW; 1 LEDG[7:0] RW; 2 HEXVAL[15:0] RW, with nibble n driving HEXn; 3 SW[9:0] RO, debounced; 4 KEY_LEVEL[3:0] RO, debounced, 1 = pressed; 5 KEY_EVENT[3:0], sticky, write-1-to-clear.
REQ-018 Unused bits and unmapped indices SHALL read 0; writes to RO or unmapped indices SHALL be ignored, and a response SHALL still be returned.
REQ-019 FSM states: IDLE and RESP. req_ready = 1 only in IDLE.
REQ-020 IDLE with req_valid: accept the request, apply any write in the same edge, latch read data, and go to RESP; resp_valid SHALL rise exactly one cycle after acceptance.
REQ-021 RESP: hold resp_valid and resp_rdata stable until resp_ready, then return to IDLE. No request is accepted in RESP, so back-to-back throughput is one transaction per 2 cycles minimum.
REQ-022 Read data is the register value before any same-cycle update. A KEY_EVENT read does not clear it.
REQ-023 Each SW and KEY bit SHALL pass through a 2-flop synchronizer, then a per-bit debouncer.
REQ-024 Debouncer behaviour:
 - If the synchronized value equals the stable value, the count is 0.
 - Otherwise the count increments.
 - When the count reaches DEBOUNCE_CYCLES-1, the stable value takes the synchronized value and the count returns to 0.
 - A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change the stable value.
REQ-025 KEY_LEVEL = inverted debounced KEY.
REQ-026 KEY_EVENT[i] SHALL set on the cycle KEY_LEVEL[i] rises 0->1.
REQ-027 When a KEY_EVENT set and a write-1-to-clear coincide on the same bit, the set SHALL win.
REQ-028 HEXn = combinational decode of HEXVAL nibble n, covering 0-9 and A-F (lowercase b and d); registered HEXVAL means no glitch on a write.

Reset
REQ-029 On RESET, outputs and state SHALL take these values:
 - LEDR = 0, LEDG = 0, HEXVAL = 0, so every HEXn shows "0" (7'b1000000).
 - KEY_EVENT = 0; FSM = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0.
 - Debounce counters = 0; SW stable = 0; KEY stable = 4'b1111 (not pressed).
REQ-030 RESET asserted in RESP SHALL drop the pending response without emitting it; RESET overrides every same-cycle event.

Structure
REQ-031 Shared package board_io_pkg SHALL hold:
 - the register index constants;
 - the FSM state enum;
 - the 16-entry seven-segment lookup constant.
REQ-032 Sub-module input_debounce, parameterized by width and DEBOUNCE_CYCLES, contains the synchronizer and debouncer and is instantiated once for SW and once for KEY.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Write idx0 = 0xA5, then read idx0: resp_valid 1 cycle after each accept, read returns 0x000000A5, LEDR = 8'hA5.
REQ-034 Write idx2 = 0x12EF: HEX3..HEX0 = "1", "2", "E", "F" (7'b1111001, 7'b0100100, 7'b0000110, 7'b0001110).
REQ-035 Drive SW = 10'h3FF for 3 cycles and then 0, and read idx3: returns 0. Hold SW = 0x3FF for 10 cycles: read idx3 returns 0x3FF.
REQ-036 Press KEY[2] (drive 0) for 10 cycles, release, and read idx5: returns 0x4. Write idx5 = 0x4, then read: returns 0. Set and clear on the same cycle: bit stays 1.
REQ-037 Hold resp_ready low 5 cycles in RESP: resp_valid and resp_rdata stay stable and req_ready stays 0. Assert RESET in RESP: next cycle resp_valid = 0, LEDR = 0.
